// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Receives a framed byte stream (LEN_LO, LEN_HI, 4*N data bytes, CSUM),
// packs the data bytes into little-endian 32-bit words and writes them to
// consecutive word addresses. The core is held in reset until the whole
// image is written and the XOR checksum has matched.
//
// Handshake: a byte transfers on any posedge where in_valid and in_ready
// are both high. The host may hold in_valid low for any number of cycles,
// and the loader keeps all of its partial state while it waits. in_ready
// depends only on the loader state and never on in_valid.
module imem_loader #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [16:0] DEPTH_L  = 17'(DEPTH_WORDS);
  localparam logic [15:0] DEPTH_16 = 16'(DEPTH_WORDS);

  state_t            state;
  state_t            state_nx;
  logic              fire;
  logic [15:0]       len;
  logic [15:0]       len_in;
  logic              len_too_big;
  logic [1:0]        lane;
  logic [23:0]       word_buf;
  logic [7:0]        csum;
  logic              last_word;
  logic [ADDR_W-1:0] word_addr;

  assign fire        = in_valid & in_ready;
  // Full length as it will be once the high byte in in_data is captured.
  assign len_in      = {in_data, len[7:0]};
  assign len_too_big = {1'b0, len_in} > DEPTH_L;
  // True while the byte on the link completes the final word of the image.
  assign last_word   = (lane == 2'd3) && ((words_loaded + 16'd1) == len);
  assign word_addr   = ADDR_W'(words_loaded) << 2;
  assign dbg_state   = state;

  // Next-state decode for the frame parser.
  always_comb begin
    state_nx = state;
    case (state)
      S_LEN0: begin
        if (fire) state_nx = S_LEN1;
      end
      S_LEN1: begin
        if (fire) begin
          if (len_too_big)          state_nx = S_ERR;
          else if (len_in == 16'd0) state_nx = S_CHECK;
          else                      state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (fire && last_word) state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (fire) state_nx = (in_data == csum) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (start) state_nx = S_LEN0;
      end
      default: state_nx = S_LEN0;
    endcase
  end

  // State register; the status outputs are decoded from the next state so
  // that they are flops aligned with the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_LEN0;
      in_ready <= 1'b1;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx == S_LEN0) || (state_nx == S_LEN1) ||
                  (state_nx == S_DATA) || (state_nx == S_CHECK);
      cpu_hold <= (state_nx != S_DONE);
      done     <= (state_nx == S_DONE);
      error    <= (state_nx == S_ERR);
    end
  end

  // Length capture, word assembly, running checksum and memory write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len          <= '0;
      lane         <= '0;
      word_buf     <= '0;
      csum         <= '0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      // The strobe is a single-cycle pulse unless re-armed below.
      mem_write <= 1'b0;
      case (state)
        S_LEN0: begin
          if (fire) len[7:0] <= in_data;
        end
        S_LEN1: begin
          if (fire) len[15:8] <= in_data;
        end
        S_DATA: begin
          if (fire) begin
            csum <= csum ^ in_data;
            if (lane == 2'd3) begin
              mem_write <= 1'b1;
              mem_addr  <= word_addr;
              mem_wdata <= {in_data, word_buf};
              lane      <= 2'd0;
              if (words_loaded != DEPTH_16) words_loaded <= words_loaded + 16'd1;
            end else begin
              case (lane)
                2'd0:    word_buf[7:0]   <= in_data;
                2'd1:    word_buf[15:8]  <= in_data;
                default: word_buf[23:16] <= in_data;
              endcase
              lane <= lane + 2'd1;
            end
          end
        end
        S_DONE, S_ERR: begin
          // A reload clears the per-image progress; memory is left alone.
          if (start) begin
            words_loaded <= '0;
            lane         <= '0;
            csum         <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames, a frame-level reference model
// that turns each frame into expected writes and a final status, and one
// monitor that checks every write strobe against that expectation.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;
  logic [2:0]  dbg_state;

  imem_loader #(.DEPTH_WORDS(1024), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_loaded(words_loaded),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected writes as {byte address, word}
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  logic [7:0]  frame[$];
  logic        exp_done;
  logic        exp_err;
  logic [15:0] exp_words;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the next expected write; status
  // outputs must stay mutually consistent on every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_write) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual addr=0x%0h data=0x%0h expected no write", mem_addr, mem_wdata);
        end else begin
          exp_e = exp_q.pop_front();
          check("wr_addr", mem_addr, exp_e[63:32]);
          check("wr_data", mem_wdata, exp_e[31:0]);
          check("wr_count", {16'h0, words_loaded}, (exp_e[63:32] >> 2) + 32'd1);
        end
      end
      check("hold_vs_done", {31'h0, cpu_hold}, {31'h0, ~done});
      if (done) check("done_after_writes", exp_q.size(), 0);
    end
  end

  // Frame construction helpers
  task automatic new_frame(input int n);
    frame.delete();
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) frame.push_back(w[8*i +: 8]);
  endtask

  function automatic logic [7:0] data_xor();
    logic [7:0] x = 8'h00;
    for (int i = 2; i < frame.size(); i++) x ^= frame[i];
    return x;
  endfunction

  // Reference model: interpret the whole frame.
  task automatic model_frame();
    int n;
    logic [7:0] x;
    n = {frame[1], frame[0]};
    exp_q.delete();
    if (n > 1024) begin
      exp_err = 1'b1; exp_done = 1'b0; exp_words = 16'd0;
    end else begin
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({32'(i * 4), frame[2+4*i+3], frame[2+4*i+2], frame[2+4*i+1], frame[2+4*i]});
        for (int k = 0; k < 4; k++) x ^= frame[2+4*i+k];
      end
      exp_done  = (frame[2+4*n] == x);
      exp_err   = !exp_done;
      exp_words = 16'(n);
    end
  endtask

  // Driver
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 expected=1 within 50 cycles");
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input int count, input bit toggle);
    int n;
    n = (count < 0) ? frame.size() : count;
    for (int i = 0; i < n; i++) begin
      send_byte(frame[i]);
      if (toggle) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_check(input string tag);
    for (int t = 0; t < 20 && !(done || error); t++) @(negedge clk);
    @(negedge clk);
    #1;
    check({tag, "_done"}, {31'h0, done}, {31'h0, exp_done});
    check({tag, "_error"}, {31'h0, error}, {31'h0, exp_err});
    check({tag, "_hold"}, {31'h0, cpu_hold}, {31'h0, ~exp_done});
    check({tag, "_words"}, {16'h0, words_loaded}, {16'h0, exp_words});
    check({tag, "_ready"}, {31'h0, in_ready}, 32'h0);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, "_rs_done"}, {31'h0, done}, 32'h0);
    check({tag, "_rs_error"}, {31'h0, error}, 32'h0);
    check({tag, "_rs_hold"}, {31'h0, cpu_hold}, 32'h1);
    check({tag, "_rs_ready"}, {31'h0, in_ready}, 32'h1);
    check({tag, "_rs_words"}, {16'h0, words_loaded}, 32'h0);
    check({tag, "_rs_state"}, {29'h0, dbg_state}, 32'h0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ready"}, {31'h0, in_ready}, 32'h1);
    check({tag, "_hold"}, {31'h0, cpu_hold}, 32'h1);
    check({tag, "_wr"}, {31'h0, mem_write}, 32'h0);
    check({tag, "_addr"}, mem_addr, 32'h0);
    check({tag, "_wdata"}, mem_wdata, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_error"}, {31'h0, error}, 32'h0);
    check({tag, "_words"}, {16'h0, words_loaded}, 32'h0);
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    #1;
    reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: two-word image, matching checksum
    new_frame(2);
    add_word(32'h0000_0013);
    add_word(32'h0010_0093);
    check("t1_xor_literal", {24'h0, data_xor()}, 32'h90);
    frame.push_back(8'h90);
    model_frame();
    check("t1_model_w0", exp_q[0][31:0], 32'h0000_0013);
    check("t1_model_a1", exp_q[1][63:32], 32'h4);
    check("t1_model_w1", exp_q[1][31:0], 32'h0010_0093);
    check("t1_model_done", {31'h0, exp_done}, 32'h1);
    send_frame(-1, 1'b0);
    finish_check("t1");
    pulse_start("t1");

    // 2: same image, wrong checksum
    new_frame(2);
    add_word(32'h0000_0013);
    add_word(32'h0010_0093);
    frame.push_back(8'h00);
    model_frame();
    check("t2_model_err", {31'h0, exp_err}, 32'h1);
    send_frame(-1, 1'b0);
    finish_check("t2");
    pulse_start("t2");

    // 3: oversize length rejected after LEN_HI
    new_frame(16'h0401);
    model_frame();
    send_frame(-1, 1'b0);
    finish_check("t3");
    pulse_start("t3");

    // 4: empty image
    new_frame(0);
    frame.push_back(8'h00);
    model_frame();
    send_frame(-1, 1'b0);
    finish_check("t4");
    pulse_start("t4");

    // 5: one word with in_valid toggling every cycle
    new_frame(1);
    add_word(32'hDEAD_BEEF);
    frame.push_back(data_xor());
    model_frame();
    send_frame(-1, 1'b1);
    finish_check("t5");
    pulse_start("t5");

    // 6: reset in the middle of a three-word image, then a clean reload
    new_frame(3);
    add_word(32'h1122_3344);
    add_word(32'h5566_7788);
    add_word(32'h99AA_BBCC);
    frame.push_back(data_xor());
    model_frame();
    send_frame(8, 1'b0);
    repeat (2) @(negedge clk);
    check("t6_pending", exp_q.size(), 2);
    rst_n = 1'b0;
    #1;
    reset_checks("t6_rst");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    model_frame();
    send_frame(-1, 1'b0);
    finish_check("t6");
    pulse_start("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
